// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer for the MIPS front end.
// Owns the fetch PC, issues one request at a time on the SRAM-like
// instruction bus, applies redirects (eret > exception > branch), drops
// responses made obsolete by a redirect, and buffers one instruction for
// decode.
//
// Handshakes:
//   bus request : inst_req/inst_addr are held stable until inst_addr_ok is
//                 seen high in the same cycle; a redirect never withdraws a
//                 presented request. inst_data_ok arrives no earlier than the
//                 cycle after inst_addr_ok; at most one request is outstanding.
//   decode      : an instruction moves to decode on a cycle with
//                 if_valid & id_allowin; if_pc/if_inst stay stable while
//                 if_valid is high and id_allowin is low.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EXC_VEC  = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_oc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        redir;
  logic [31:0] redir_tgt;

  // Redirect request and its target, resolved by fixed priority.
  always_comb begin
    redir     = eret | exc_oc | br_take;
    redir_tgt = br_target;
    if (eret) begin
      redir_tgt = epc;
    end else if (exc_oc) begin
      redir_tgt = EXC_VEC;
    end
  end

  // Next-state and register updates for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    case (state_q)
      S_IDLE: begin
        fetch_pc_d = RESET_PC;
        state_d    = S_REQ;
      end

      S_REQ: begin
        // The presented request cannot be withdrawn, so a redirect is
        // remembered and its eventual response marked for dropping.
        if (redir) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redir_tgt;
          discard_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (inst_data_ok) begin
          if (discard_q || redir) begin
            // Stale response: drop it and restart at the newest target.
            if (redir) begin
              fetch_pc_d = redir_tgt;
            end else if (pend_v_q) begin
              fetch_pc_d = pend_pc_q;
            end
            discard_d = 1'b0;
            pend_v_d  = 1'b0;
            state_d   = S_REQ;
          end else begin
            if_inst_d  = inst_rdata;
            if_pc_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redir_tgt;
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        // A transfer in the redirect cycle is still delivered; without one
        // the buffered instruction is simply abandoned.
        if (redir) begin
          fetch_pc_d = redir_tgt;
          state_d    = S_REQ;
        end else if (id_allowin) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'd0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign inst_req  = (state_q == S_REQ);
  assign inst_addr = fetch_pc_q;
  assign if_valid  = (state_q == S_HOLD);
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule
